// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory read port, EX redirect and the decode handshake.
// The master side is the fetch queue; the slave side is memory, EX and decode.
interface inst_fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 14
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_rdata;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              d_valid;
    logic              d_ready;
    logic [31:0]       d_inst;
    logic [31:0]       d_pc;
    logic [CNT_W-1:0]  count;

    modport master (
        output im_req, im_addr, d_valid, d_inst, d_pc, count,
        input  im_rdata, redirect, redirect_pc, d_ready
    );

    modport slave (
        input  im_req, im_addr, d_valid, d_inst, d_pc, count,
        output im_rdata, redirect, redirect_pc, d_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, reads IM one word per cycle and buffers
// {pc, inst} pairs for decode so a decode stall never re-reads IM; EX redirects flush everything.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic                 clk,
    input logic                 rst,
    inst_fetch_queue_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic [31:0]      fetch_pc;
    logic [31:0]      req_pc;
    logic             inflight;
    ptr_t             rd_ptr;
    ptr_t             wr_ptr;
    logic [CNT_W-1:0] count;
    entry_t           entries [DEPTH];

    logic             issue;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic [CNT_W:0]   occupancy;
    entry_t           head;

    // Reserving a slot for the in-flight word is what lets a push never land on a full queue.
    always_comb begin
        occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        head_valid = (count != '0);
        issue      = rst & ~bus.redirect & (occupancy < (CNT_W + 1)'(DEPTH));
        push       = inflight & ~bus.redirect;
        pop        = head_valid & bus.d_ready & ~bus.redirect;
        head       = entries[rd_ptr];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
            inflight <= issue;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: the entry storage has no reset; count gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr] <= '{pc: req_pc, inst: bus.im_rdata};
    end

    assign bus.im_req  = issue;
    assign bus.im_addr = fetch_pc[ADDR_W+1:2];
    assign bus.d_valid = head_valid;
    assign bus.d_inst  = head_valid ? head.inst : 32'h0;
    assign bus.d_pc    = head_valid ? head.pc   : 32'h0;
    assign bus.count   = count;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: cycle table from reset, directed redirect/reset
// sequences, then random stalls and redirects against a queue-based reference model.
module tb_inst_fetch_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 14;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] im_word(input logic [ADDR_W-1:0] a);
        return 32'hA000_0000 + {{(32-ADDR_W){1'b0}}, a};
    endfunction

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return im_word(pc[ADDR_W+1:2]);
    endfunction

    // Instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.im_req) bus.im_rdata <= im_word(bus.im_addr);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rdy, input logic rd, input logic [31:0] rpc);
        bus.d_ready     = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        rst = 1'b1;
        #1;
    endtask

    // Waits with inputs held for d_valid; an expired bound counts as a failed comparison.
    task automatic wait_valid(input string name);
        for (int i = 0; i < 10; i++) begin
            if (bus.d_valid) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s: got d_valid=0 expected d_valid=1 within 10 cycles", name);
    endtask

    typedef struct {
        logic              rdy;
        logic              exp_req;
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_valid;
        logic [31:0]       exp_pc;
        int                exp_count;
    } vec_t;

    vec_t vecs [13];

    // Reference model state for the random phase.
    logic [31:0] m_q [$];
    logic [31:0] m_fetch;
    logic [31:0] m_req_pc;
    bit          m_infl;
    logic [31:0] stream_next;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Cycle-by-cycle table from reset release: streaming, then a 4-cycle stall, then release.
        vecs[0]  = '{1'b1, 1'b1, 14'd0, 1'b0, 32'h00, 0};
        vecs[1]  = '{1'b1, 1'b1, 14'd1, 1'b0, 32'h00, 0};
        vecs[2]  = '{1'b1, 1'b1, 14'd2, 1'b1, 32'h00, 1};
        vecs[3]  = '{1'b1, 1'b1, 14'd3, 1'b1, 32'h04, 1};
        vecs[4]  = '{1'b0, 1'b1, 14'd4, 1'b1, 32'h08, 1};
        vecs[5]  = '{1'b0, 1'b1, 14'd5, 1'b1, 32'h08, 2};
        vecs[6]  = '{1'b0, 1'b0, 14'd6, 1'b1, 32'h08, 3};
        vecs[7]  = '{1'b0, 1'b0, 14'd6, 1'b1, 32'h08, 4};
        vecs[8]  = '{1'b1, 1'b0, 14'd6, 1'b1, 32'h08, 4};
        vecs[9]  = '{1'b1, 1'b1, 14'd6, 1'b1, 32'h0C, 3};
        vecs[10] = '{1'b1, 1'b1, 14'd7, 1'b1, 32'h10, 2};
        vecs[11] = '{1'b1, 1'b1, 14'd8, 1'b1, 32'h14, 2};
        vecs[12] = '{1'b1, 1'b1, 14'd9, 1'b1, 32'h18, 2};

        drive(1'b0, 1'b0, 32'h0);
        #2;
        check("reset_im_req",  32'(bus.im_req),  32'h0);
        check("reset_d_valid", 32'(bus.d_valid), 32'h0);
        check("reset_d_inst",  bus.d_inst,       32'h0);
        check("reset_d_pc",    bus.d_pc,         32'h0);
        check("reset_count",   32'(bus.count),   32'h0);

        // T1/T2: table-driven streaming and stall
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rdy, 1'b0, 32'h0);
            #1;
            check($sformatf("tbl%0d_im_req", i),  32'(bus.im_req),  32'(vecs[i].exp_req));
            if (vecs[i].exp_req)
                check($sformatf("tbl%0d_im_addr", i), 32'(bus.im_addr), 32'(vecs[i].exp_addr));
            check($sformatf("tbl%0d_d_valid", i), 32'(bus.d_valid), 32'(vecs[i].exp_valid));
            check($sformatf("tbl%0d_d_pc", i),    bus.d_pc,         vecs[i].exp_pc);
            check($sformatf("tbl%0d_d_inst", i),  bus.d_inst,
                  vecs[i].exp_valid ? inst_of(vecs[i].exp_pc) : 32'h0);
            check($sformatf("tbl%0d_count", i),   32'(bus.count),   32'(vecs[i].exp_count));
            tick();
        end

        // T3: three queued plus one in flight, then redirect to an unaligned target
        do_reset();
        drive(1'b0, 1'b0, 32'h0);
        repeat (4) tick();
        check("t3_pre_count",  32'(bus.count),  32'd3);
        check("t3_pre_im_req", 32'(bus.im_req), 32'h0);
        drive(1'b0, 1'b1, 32'h0000_0103);
        #1;
        check("t3_redir_im_req", 32'(bus.im_req), 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        #1;
        check("t3_post_count",   32'(bus.count),   32'h0);
        check("t3_post_d_valid", 32'(bus.d_valid), 32'h0);
        check("t3_post_d_inst",  bus.d_inst,       32'h0);
        check("t3_post_im_req",  32'(bus.im_req),  32'h1);
        check("t3_post_im_addr", 32'(bus.im_addr), 32'h40);
        tick();
        check("t3_gap_d_valid", 32'(bus.d_valid), 32'h0);
        tick();
        check("t3_first_d_valid", 32'(bus.d_valid), 32'h1);
        check("t3_first_d_pc",    bus.d_pc,         32'h100);
        check("t3_first_d_inst",  bus.d_inst,       inst_of(32'h100));
        tick();
        check("t3_second_d_pc",   bus.d_pc,         32'h104);

        // T4: redirect in the same cycle as a pop
        check("t4_pre_d_valid", 32'(bus.d_valid), 32'h1);
        drive(1'b1, 1'b1, 32'h0000_0200);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        #1;
        check("t4_post_count",   32'(bus.count),   32'h0);
        check("t4_post_d_valid", 32'(bus.d_valid), 32'h0);
        wait_valid("t4_wait");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_d_pc%0d", i),   bus.d_pc,   32'h200 + 32'(4 * i));
            check($sformatf("t4_d_inst%0d", i), bus.d_inst, inst_of(32'h200 + 32'(4 * i)));
            tick();
        end

        // T5: asynchronous reset between edges while streaming
        #2;
        rst = 1'b0;
        #1;
        check("t5_d_valid", 32'(bus.d_valid), 32'h0);
        check("t5_d_pc",    bus.d_pc,         32'h0);
        check("t5_d_inst",  bus.d_inst,       32'h0);
        check("t5_count",   32'(bus.count),   32'h0);
        check("t5_im_req",  32'(bus.im_req),  32'h0);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("t5_restart_im_addr", 32'(bus.im_addr), 32'h0);
        wait_valid("t5_wait");
        check("t5_first_d_pc",   bus.d_pc,   32'h0);
        check("t5_first_d_inst", bus.d_inst, inst_of(32'h0));

        // T6: random stalls and redirects against the reference model
        do_reset();
        m_q.delete();
        m_fetch     = 32'h0;
        m_req_pc    = 32'h0;
        m_infl      = 1'b0;
        stream_next = 32'h0;
        begin
            int  pops;
            int  cyc;
            bit  rdy;
            bit  rd;
            bit  exp_req;
            bit  do_pop;
            logic [31:0] rpc;
            pops = 0;
            cyc  = 0;
            while (pops < 1000 && cyc < 20000) begin
                rdy = ($urandom % 2) == 0;
                rd  = ($urandom % 32) == 0;
                rpc = $urandom;
                drive(rdy, rd, rpc);
                #1;
                exp_req = !rd && (m_q.size() + int'(m_infl) < DEPTH);
                check("rnd_im_req",  32'(bus.im_req), 32'(exp_req));
                if (exp_req) check("rnd_im_addr", 32'(bus.im_addr), 32'(m_fetch[ADDR_W+1:2]));
                check("rnd_d_valid", 32'(bus.d_valid), 32'(m_q.size() > 0));
                check("rnd_d_pc",    bus.d_pc,   (m_q.size() > 0) ? m_q[0] : 32'h0);
                check("rnd_d_inst",  bus.d_inst, (m_q.size() > 0) ? inst_of(m_q[0]) : 32'h0);
                check("rnd_count",   32'(bus.count), 32'(m_q.size()));
                check("rnd_count_bound", 32'(bus.count <= DEPTH), 32'h1);

                do_pop = !rd && rdy && (m_q.size() > 0);
                if (do_pop) begin
                    check("rnd_stream_pc", bus.d_pc, stream_next);
                    stream_next = stream_next + 32'd4;
                    pops++;
                end

                if (rd) begin
                    m_q.delete();
                    m_infl      = 1'b0;
                    m_fetch     = {rpc[31:2], 2'b00};
                    stream_next = {rpc[31:2], 2'b00};
                end else begin
                    if (do_pop) void'(m_q.pop_front());
                    if (m_infl) m_q.push_back(m_req_pc);
                    if (exp_req) begin
                        m_req_pc = m_fetch;
                        m_fetch  = m_fetch + 32'd4;
                    end
                    m_infl = exp_req;
                end
                tick();
                cyc++;
            end
            check("rnd_pop_total", 32'(pops), 32'd1000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
